uart_rx: RTL
============

Name: uart_rx

Overview:
Serial receiver that sits directly downstream of uart_tx on the serial line: it consumes the UART bitstream and delivers parallel words to user logic. It synchronises the asynchronous line, qualifies the start bit, samples each bit at mid-bit, and checks the stop bit(s). It shares the parameter set of uart_tx, so one loopback (tx → rx) pair works with identical settings.

Parameters:
P_SYSTEM_CLK  50_000_000  i_clk frequency in Hz
P_UART_BUADRATE  9600  line baud rate
P_UART_DATA_WIDTH  8  data bits per frame, LSB first
P_UART_STOP_WIDTH  1  stop bits per frame (1 or 2)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_uart_rx  in  1  serial line, asynchronous, idle high
o_user_rx_data  out  P_UART_DATA_WIDTH  last good received word
o_user_rx_valid  out  1  one-cycle pulse: o_user_rx_data is new
o_rx_frame_err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Clocking and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Constants: DIV = P_SYSTEM_CLK / P_UART_BUADRATE (integer truncation; 5208 at defaults). HALF = DIV/2. DIV must be ≥ 4 (elaboration check).
- Reset values: o_user_rx_data = 0, o_user_rx_valid = 0, o_rx_frame_err = 0. Synchroniser flops and the previous-line flop = 1. State = IDLE, counters = 0.
- Input conditioning: 2-FF synchroniser on i_uart_rx, then a previous-value register. A falling edge is synced=0 while prev=1.
- No backpressure: the user must accept each valid pulse. Data holds until the next good frame.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on a falling edge, go to START with baud cnt = 0.
- START: increment cnt. When cnt == HALF-1, sample the line.
  - Line = 0: go to DATA with cnt = 0, bit_idx = 0.
  - Line = 1: glitch; go to IDLE with no output.
- DATA: increment cnt. When cnt == DIV-1, sample into shift register bit bit_idx (LSB first) and set cnt = 0.
  - After bit P_UART_DATA_WIDTH-1, go to STOP with stop_idx = 0.
- STOP: when cnt == DIV-1, sample the stop bit. Any low stop sample sets a sticky err flag for the frame.
  - After sample P_UART_STOP_WIDTH-1, go to IDLE.
  - Next cycle, if err = 0: load o_user_rx_data and pulse o_user_rx_valid.
  - Next cycle, if err = 1: pulse o_rx_frame_err; data is unchanged and valid stays 0.
- Return to IDLE happens at mid-last-stop-bit, so back-to-back frames are detected.
- Latency: o_user_rx_valid is high exactly HALF + DIV·(P_UART_DATA_WIDTH + P_UART_STOP_WIDTH) + 1 cycles after the IDLE cycle that detects the edge. The edge is detected 3 cycles after i_uart_rx falls.
- Line break (line held low): produces a framing error, then IDLE. No retrigger occurs until the line returns high and falls again, because the edge detector needs prev = 1.
- Reset mid-frame: the next cycle is IDLE with outputs 0, and no pulse is emitted for the partial frame.
- Pulses never overlap. o_user_rx_valid and o_rx_frame_err are never high in the same cycle.

Decomposition:
- Shared package/header uart_defs:
  - FSM state encodings (2-bit localparams).
  - Baud divisor macro/function shared with uart_tx.
  - Counter width = $clog2(DIV).
- One natural sub-module: uart_rx_sync, containing the 2-FF synchroniser, the prev register, and the falling-edge output. Its reset value is 1.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
Simulation uses P_SYSTEM_CLK = 1_600_000 and P_UART_BUADRATE = 100_000, so DIV = 16 and HALF = 8.
1. Single frame 0xA5, 1 stop bit, bit time 16 clk → one valid pulse, data = 0xA5, frame_err never high. Valid occurs 8 + 16·9 + 1 = 153 cycles after edge detect.
2. Back-to-back 0x00, 0xFF, 0x55, no idle gap → three valid pulses with data in order. No frame_err.
3. Start glitch: line low for 4 clk, then high → no valid, no frame_err. FSM back in IDLE; a following 0x3C frame is received correctly.
4. Stop bit forced low on frame 0x81 → one frame_err pulse, no valid, o_user_rx_data retains the previous value. Line held low 300 clk (break), then released, then frame 0x12 → only one frame_err, then valid with 0x12.
5. i_rst asserted mid-DATA for one cycle → outputs 0 next cycle, no pulse for the partial frame. The next clean frame 0x6E is received.
6. Loopback with uart_tx, P_UART_STOP_WIDTH = 2, 256 random bytes → all bytes match in order, zero framing errors.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM encoding and the baud divisor helper
// used by both uart_tx and uart_rx so a loopback pair agrees on bit timing.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic int baud_div(input int sys_clk, input int baud);
        return sys_clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge
// detector; every flop resets to the idle (high) line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic synced,
    output logic fall
);

    logic meta;
    logic stable;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b1;
            stable <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= line;
            stable <= meta;
            prev   <= stable;
        end
    end

    assign synced = stable;
    assign fall   = ~stable & prev;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit qualification at half a bit, mid-bit data sampling,
// stop-bit check, and a one-cycle valid or framing-error pulse per frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BUADRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_rx_frame_err
);

    localparam int DIV   = baud_div(P_SYSTEM_CLK, P_UART_BUADRATE);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (P_UART_DATA_WIDTH > 1) ? $clog2(P_UART_DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(P_UART_DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(P_UART_STOP_WIDTH - 1);

    if (DIV < 4) begin : g_bad_div
        $error("uart_rx: baud divisor must be at least 4");
    end
    if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_bad_stop
        $error("uart_rx: stop width must be 1 or 2");
    end

    logic synced;
    logic fall;

    uart_rx_sync u_sync (
        .clk    (i_clk),
        .rst    (i_rst),
        .line   (i_uart_rx),
        .synced (synced),
        .fall   (fall)
    );

    rx_state_t                    state;
    logic [CNT_W-1:0]             cnt;
    logic [IDX_W-1:0]             bit_idx;
    logic                         stop_idx;
    logic [P_UART_DATA_WIDTH-1:0] shift_reg;
    logic                         err;
    logic                         done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            shift_reg       <= '0;
            err             <= 1'b0;
            done            <= 1'b0;
            o_user_rx_data  <= '0;
            o_user_rx_valid <= 1'b0;
            o_rx_frame_err  <= 1'b0;
        end else begin
            done            <= 1'b0;
            o_user_rx_valid <= 1'b0;
            o_rx_frame_err  <= 1'b0;

            // Frame result is published the cycle after the last stop sample.
            if (done) begin
                if (err) begin
                    o_rx_frame_err <= 1'b1;
                end else begin
                    o_user_rx_valid <= 1'b1;
                    o_user_rx_data  <= shift_reg;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (cnt == CNT_MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= synced ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= synced;
                        if (bit_idx == IDX_LAST) begin
                            state    <= ST_STOP;
                            stop_idx <= 1'b0;
                            err      <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!synced) begin
                            err <= 1'b1;
                        end
                        // Leaving at mid-stop lets a back-to-back start edge be caught.
                        if (stop_idx == STOP_LAST) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
